// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan controller: segment codes,
// scan FSM state encoding and a small elaboration-time helper.
package seg_pkg;

  // Scan FSM states
  typedef enum logic [1:0] {
    OFF   = 2'd0,
    GUARD = 2'd1,
    ON    = 2'd2
  } scan_state_t;

  // Active-low pattern with every segment dark
  localparam logic [6:0] SEG_BLANK = 7'b111_1111;

  // Active-low segment codes {g,f,e,d,c,b,a} for decimal digits 0..9
  localparam logic [6:0] SEG_CODE [0:9] = '{
    7'b100_0000,  // 0
    7'b111_1001,  // 1
    7'b010_0100,  // 2
    7'b011_0000,  // 3
    7'b001_1001,  // 4
    7'b001_0010,  // 5
    7'b000_0010,  // 6
    7'b111_1000,  // 7
    7'b000_0000,  // 8
    7'b001_0000   // 9
  };

  // Larger of two integers, used to size the shared slot counter
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seg_decoder.sv
// BCD to active-low 7-segment decoder. Non-decimal codes and blanked
// digits produce an all-dark pattern.
module seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  // Look up the segment pattern for one digit, forcing dark when blanked
  always_comb begin
    seg = SEG_BLANK;
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      case (bcd)
        4'd0:    seg = SEG_CODE[0];
        4'd1:    seg = SEG_CODE[1];
        4'd2:    seg = SEG_CODE[2];
        4'd3:    seg = SEG_CODE[3];
        4'd4:    seg = SEG_CODE[4];
        4'd5:    seg = SEG_CODE[5];
        4'd6:    seg = SEG_CODE[6];
        4'd7:    seg = SEG_CODE[7];
        4'd8:    seg = SEG_CODE[8];
        4'd9:    seg = SEG_CODE[9];
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode 7-segment digits.
// Walks the digits with an all-dark guard slot before each one, and only
// swaps in newly loaded display data at frame boundaries (or while idle).
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int ON_CYCLES    = 50000,
  parameter int GUARD_CYCLES = 500
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      load_valid,
  output logic                      load_ready,
  input  logic [4*NUM_DIGITS-1:0]   load_digits,
  input  logic [NUM_DIGITS-1:0]     load_blank,
  output logic [NUM_DIGITS-1:0]     anode_n,
  output logic [6:0]                segments,
  output logic                      frame_tick
);

  // Counter is floored at 2 so it never collapses to zero width
  localparam int CNT_MAX = max_int(max_int(ON_CYCLES, GUARD_CYCLES), 2);
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int IDX_W   = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0]      ON_LAST    = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0]      GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
  // Explicit last-index compare keeps non-power-of-2 digit counts wrapping
  localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF  = {NUM_DIGITS{1'b1}};
  localparam logic [NUM_DIGITS-1:0] ANODE_ONE  = NUM_DIGITS'(1);

  scan_state_t             state_r;
  logic [CNT_W-1:0]        cnt_r;
  logic [IDX_W-1:0]        digit_idx_r;
  logic [NUM_DIGITS-1:0]   anode_n_r;
  logic [6:0]              segments_r;
  logic                    frame_tick_r;
  logic                    load_ready_r;

  logic [4*NUM_DIGITS-1:0] shadow_digits_r;
  logic [NUM_DIGITS-1:0]   shadow_blank_r;
  logic [4*NUM_DIGITS-1:0] active_digits_r;
  logic [NUM_DIGITS-1:0]   active_blank_r;

  logic [3:0]              sel_bcd_s;
  logic                    sel_blank_s;
  logic [6:0]              dec_seg_s;
  logic                    frame_end_s;
  logic                    accept_s;
  logic                    apply_s;

  // Pick the active data of the digit about to be lit for the shared decoder
  always_comb begin
    sel_bcd_s   = active_digits_r[{digit_idx_r, 2'b00} +: 4];
    sel_blank_s = active_blank_r[digit_idx_r];
  end

  seg_decoder u_dec (
    .bcd   (sel_bcd_s),
    .blank (sel_blank_s),
    .seg   (dec_seg_s)
  );

  // Detect the frame boundary and decide between accepting and applying data
  always_comb begin
    frame_end_s = 1'b0;
    if (enable && (state_r == ON) && (cnt_r == ON_LAST) &&
        (digit_idx_r == IDX_LAST)) begin
      frame_end_s = 1'b1;
    end else begin
      frame_end_s = 1'b0;
    end
    // Shadow empty means ready; full shadow means a load is pending, so the
    // accept and apply paths can never fire together.
    accept_s = load_valid && load_ready_r;
    apply_s  = !load_ready_r && ((state_r == OFF) || frame_end_s);
  end

  // Scan FSM with registered anode, segment and frame pulse outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= OFF;
      cnt_r        <= '0;
      digit_idx_r  <= '0;
      anode_n_r    <= ANODE_OFF;
      segments_r   <= SEG_BLANK;
      frame_tick_r <= 1'b0;
    end else if (!enable) begin
      state_r      <= OFF;
      cnt_r        <= '0;
      digit_idx_r  <= '0;
      anode_n_r    <= ANODE_OFF;
      segments_r   <= SEG_BLANK;
      frame_tick_r <= 1'b0;
    end else begin
      frame_tick_r <= 1'b0;
      case (state_r)
        OFF: begin
          state_r     <= GUARD;
          cnt_r       <= '0;
          digit_idx_r <= '0;
          anode_n_r   <= ANODE_OFF;
          segments_r  <= SEG_BLANK;
        end
        GUARD: begin
          if (cnt_r == GUARD_LAST) begin
            state_r    <= ON;
            cnt_r      <= '0;
            anode_n_r  <= ~(ANODE_ONE << digit_idx_r);
            segments_r <= dec_seg_s;
          end else begin
            cnt_r      <= cnt_r + CNT_W'(1);
            anode_n_r  <= ANODE_OFF;
            segments_r <= SEG_BLANK;
          end
        end
        ON: begin
          if (cnt_r == ON_LAST) begin
            state_r    <= GUARD;
            cnt_r      <= '0;
            anode_n_r  <= ANODE_OFF;
            segments_r <= SEG_BLANK;
            if (digit_idx_r == IDX_LAST) begin
              digit_idx_r  <= '0;
              frame_tick_r <= 1'b1;
            end else begin
              digit_idx_r  <= digit_idx_r + IDX_W'(1);
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r     <= OFF;
          cnt_r       <= '0;
          digit_idx_r <= '0;
          anode_n_r   <= ANODE_OFF;
          segments_r  <= SEG_BLANK;
        end
      endcase
    end
  end

  // Load handshake: capture into the shadow, then copy to active at a frame
  // boundary or straight away while the scanner is idle
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_digits_r <= '0;
      shadow_blank_r  <= '0;
      active_digits_r <= '0;
      active_blank_r  <= '0;
      load_ready_r    <= 1'b1;
    end else if (accept_s) begin
      shadow_digits_r <= load_digits;
      shadow_blank_r  <= load_blank;
      load_ready_r    <= 1'b0;
    end else if (apply_s) begin
      active_digits_r <= shadow_digits_r;
      active_blank_r  <= shadow_blank_r;
      load_ready_r    <= 1'b1;
    end
  end

  assign anode_n    = anode_n_r;
  assign segments   = segments_r;
  assign frame_tick = frame_tick_r;
  assign load_ready = load_ready_r;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (4 digits, 8 ON cycles, 2 guard).
// Expected lit slots are queued when stimulus is set up and compared as the
// DUT scans them out.
module tb_seg_scan_ctrl;

  localparam int ND = 4;
  localparam int ON_C = 8;
  localparam int GD_C = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          load_valid;
  logic          load_ready;
  logic [15:0]   load_digits;
  logic [3:0]    load_blank;
  logic [3:0]    anode_n;
  logic [6:0]    segments;
  logic          frame_tick;

  int checks = 0;
  int passes = 0;

  typedef struct packed {
    logic [3:0] anode;
    logic [6:0] seg;
  } slot_t;

  slot_t sb_q[$];

  seg_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .ON_CYCLES    (ON_C),
    .GUARD_CYCLES (GD_C)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_digits (load_digits),
    .load_blank  (load_blank),
    .anode_n     (anode_n),
    .segments    (segments),
    .frame_tick  (frame_tick)
  );

  always #5 clk = ~clk;

  // Reference segment table
  function automatic logic [6:0] exp_code(input logic [3:0] d, input logic b);
    if (b) return 7'h7F;
    case (d)
      4'd0: return 7'b100_0000;
      4'd1: return 7'b111_1001;
      4'd2: return 7'b010_0100;
      4'd3: return 7'b011_0000;
      4'd4: return 7'b001_1001;
      4'd5: return 7'b001_0010;
      4'd6: return 7'b000_0010;
      4'd7: return 7'b111_1000;
      4'd8: return 7'b000_0000;
      4'd9: return 7'b001_0000;
      default: return 7'h7F;
    endcase
  endfunction

  // Queue the four lit slots of one frame showing the given data
  task automatic push_frame(input logic [15:0] d, input logic [3:0] b);
    slot_t e;
    for (int i = 0; i < ND; i++) begin
      e.anode = ~(4'b0001 << i);
      e.seg   = exp_code(d[4*i +: 4], b[i]);
      sb_q.push_back(e);
    end
  endtask

  // Observe n slots (guard then lit), starting on the current negedge
  task automatic collect_slots(input int n);
    slot_t e;
    int dark, lit, bad;
    for (int k = 0; k < n; k++) begin
      if (sb_q.size() == 0) begin
        checks++;
        $display("FAIL scoreboard_empty: got 0 entries, expected >0");
        return;
      end
      e = sb_q.pop_front();
      dark = 0;
      while (anode_n === 4'hF && dark < 100) begin
        dark++;
        @(negedge clk);
      end
      checks++;
      if (dark !== GD_C) $display("FAIL guard_len: got %0d expected %0d", dark, GD_C);
      else passes++;
      checks++;
      if (anode_n !== e.anode) $display("FAIL anode: got %b expected %b", anode_n, e.anode);
      else passes++;
      checks++;
      if (segments !== e.seg) $display("FAIL segments: anode %b got %b expected %b", e.anode, segments, e.seg);
      else passes++;
      lit = 0;
      bad = 0;
      while (anode_n === e.anode && lit < 100) begin
        if (segments !== e.seg || frame_tick !== 1'b0) bad++;
        lit++;
        @(negedge clk);
      end
      checks++;
      if (lit !== ON_C) $display("FAIL on_len: anode %b got %0d expected %0d", e.anode, lit, ON_C);
      else passes++;
      checks++;
      if (bad !== 0) $display("FAIL on_hold: anode %b got %0d glitches expected 0", e.anode, bad);
      else passes++;
      checks++;
      if (frame_tick !== (e.anode == 4'b0111))
        $display("FAIL frame_tick: after anode %b got %b expected %b", e.anode, frame_tick, (e.anode == 4'b0111));
      else passes++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; load_valid = 1'b0;
    load_digits = 16'h0000; load_blank = 4'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (anode_n !== 4'hF) $display("FAIL rst_anode: got %b expected 1111", anode_n);
      else passes++;
      checks++;
      if (segments !== 7'h7F) $display("FAIL rst_seg: got %h expected 7f", segments);
      else passes++;
      checks++;
      if (load_ready !== 1'b1) $display("FAIL rst_ready: got %b expected 1", load_ready);
      else passes++;
      checks++;
      if (frame_tick !== 1'b0) $display("FAIL rst_tick: got %b expected 0", frame_tick);
      else passes++;
    end
  endtask

  task automatic test_scan();
    load_digits = 16'h4321; load_blank = 4'h0; load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    checks++;
    if (load_ready !== 1'b0) $display("FAIL off_load_busy: got %b expected 0", load_ready);
    else passes++;
    @(negedge clk);
    checks++;
    if (load_ready !== 1'b1) $display("FAIL off_load_apply: got %b expected 1", load_ready);
    else passes++;
    push_frame(16'h4321, 4'h0);
    enable = 1'b1;
    @(negedge clk);
    collect_slots(4);
  endtask

  task automatic test_midframe_load();
    push_frame(16'h4321, 4'h0);
    push_frame(16'h9999, 4'h0);
    fork
      begin
        logic prev;
        int n;
        repeat (14) @(negedge clk);
        load_digits = 16'h9999; load_blank = 4'h0; load_valid = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        checks++;
        if (load_ready !== 1'b0) $display("FAIL mid_busy: got %b expected 0", load_ready);
        else passes++;
        prev = load_ready;
        n = 0;
        while (frame_tick !== 1'b1 && n < 200) begin
          prev = load_ready;
          n++;
          @(negedge clk);
        end
        checks++;
        if (prev !== 1'b0) $display("FAIL mid_ready_early: got %b expected 0", prev);
        else passes++;
        checks++;
        if (load_ready !== 1'b1 || frame_tick !== 1'b1)
          $display("FAIL mid_ready_rise: got ready %b tick %b expected 1 1", load_ready, frame_tick);
        else passes++;
      end
      collect_slots(8);
    join
  endtask

  task automatic test_blank();
    push_frame(16'h9999, 4'h0);
    push_frame(16'h765C, 4'b1010);
    fork
      begin
        load_digits = 16'h765C; load_blank = 4'b1010; load_valid = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        checks++;
        if (load_ready !== 1'b0) $display("FAIL blank_busy: got %b expected 0", load_ready);
        else passes++;
      end
      collect_slots(8);
    join
  endtask

  task automatic test_disable();
    int n;
    push_frame(16'h765C, 4'b1010);
    collect_slots(2);
    void'(sb_q.pop_front());
    void'(sb_q.pop_front());
    n = 0;
    while (anode_n === 4'hF && n < 100) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (anode_n !== 4'b1011) $display("FAIL dis_digit2: got %b expected 1011", anode_n);
    else passes++;
    repeat (3) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    checks++;
    if (anode_n !== 4'hF || segments !== 7'h7F)
      $display("FAIL dis_dark: got %b/%h expected 1111/7f", anode_n, segments);
    else passes++;
    repeat (5) @(negedge clk);
    push_frame(16'h765C, 4'b1010);
    enable = 1'b1;
    @(negedge clk);
    collect_slots(4);
  endtask

  task automatic test_rst_pending();
    int n;
    n = 0;
    while (anode_n === 4'hF && n < 100) begin
      n++;
      @(negedge clk);
    end
    load_digits = 16'h9999; load_blank = 4'h0; load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    checks++;
    if (load_ready !== 1'b0) $display("FAIL rp_busy: got %b expected 0", load_ready);
    else passes++;
    @(negedge clk);
    rst = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    checks++;
    if (anode_n !== 4'hF || segments !== 7'h7F || load_ready !== 1'b1 || frame_tick !== 1'b0)
      $display("FAIL rp_reset: got %b/%h/%b/%b expected 1111/7f/1/0", anode_n, segments, load_ready, frame_tick);
    else passes++;
    rst = 1'b0;
    @(negedge clk);
    push_frame(16'h0000, 4'h0);
    enable = 1'b1;
    @(negedge clk);
    collect_slots(4);
  endtask

  initial begin
    test_reset();
    test_scan();
    test_midframe_load();
    test_blank();
    test_disable();
    test_rst_pending();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("%0d/%0d checks passed", passes, checks + 1);
    $fatal(1, "timeout");
  end

endmodule
